fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: walks the PC through instruction memory, predecodes
// absolute jumps, and buffers fetched words in a two-entry in-order queue.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_WORDS = 32
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_ins,
   output logic [31:0] ins_out,
   output logic [31:0] pc_out,
   output logic        ins_valid,
   input  logic        ins_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        fault
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FLUSH = 2'd2,
      FAULT = 2'd3
   } state_t;

   localparam logic [29:0] WORDS_LIMIT = 30'(IMEM_WORDS);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [1:0]  count_q, count_d;
   logic [31:0] headPc_q, headPc_d, headIns_q, headIns_d;
   logic [31:0] tailPc_q, tailPc_d, tailIns_q, tailIns_d;
   logic        fault_q, fault_d;

   logic        pop, fire, inRange, push, isJump;
   logic [31:0] pcPlus4;
   logic        unusedRpcBits;

   assign unusedRpcBits = ^redirect_pc[1:0];

   assign imem_addr = pc_q;
   assign ins_valid = (count_q != 2'd0);
   assign ins_out   = ins_valid ? headIns_q : 32'h0;
   assign pc_out    = ins_valid ? headPc_q  : 32'h0;
   assign fault     = fault_q;

   assign pop     = ins_valid && ins_ready;
   assign fire    = (state_q == FETCH) && ((count_q != 2'd2) || pop);
   assign inRange = (pc_q[31:2] < WORDS_LIMIT);
   assign push    = fire && inRange && !redirect;
   assign pcPlus4 = pc_q + 32'd4;
   assign isJump  = (imem_ins[31:26] == 6'b000010);

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      count_d   = count_q;
      headPc_d  = headPc_q;
      headIns_d = headIns_q;
      tailPc_d  = tailPc_q;
      tailIns_d = tailIns_q;
      fault_d   = fault_q;

      if (redirect) begin
         // A redirect wins over everything; the handshake this cycle is simply discarded.
         count_d = 2'd0;
         pc_d    = {redirect_pc[31:2], 2'b00};
         fault_d = 1'b0;
         state_d = FLUSH;
      end else begin
         case (state_q)
            IDLE:  state_d = FETCH;
            FLUSH: state_d = FETCH;
            FETCH: begin
               if (fire && !inRange) begin
                  state_d = FAULT;
                  fault_d = 1'b1;
               end else if (push) begin
                  pc_d = isJump ? {pcPlus4[31:28], imem_ins[25:0], 2'b00} : pcPlus4;
               end
            end
            default: ;
         endcase

         if (pop) begin
            headPc_d  = tailPc_q;
            headIns_d = tailIns_q;
         end
         // The new word lands in whichever slot is the first free one after the pop.
         if (push) begin
            if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
               headPc_d  = pc_q;
               headIns_d = imem_ins;
            end else begin
               tailPc_d  = pc_q;
               tailIns_d = imem_ins;
            end
         end
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         count_q   <= 2'd0;
         headPc_q  <= 32'h0;
         headIns_q <= 32'h0;
         tailPc_q  <= 32'h0;
         tailIns_q <= 32'h0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         count_q   <= count_d;
         headPc_q  <= headPc_d;
         headIns_q <= headIns_d;
         tailPc_q  <= tailPc_d;
         tailIns_q <= tailIns_d;
         fault_q   <= fault_d;
      end
   end

endmodule
